// File: rtl/scm_pkg.sv
// Shared definitions for the scm65 March BIST: default geometry, March state
// encoding and the element/data-polarity helpers used by the sequencer.
package scm_pkg;

  localparam int          SCM_ADDR_WIDTH = 6;
  localparam int          SCM_DATA_WIDTH = 32;
  localparam int          SCM_RD_LAT     = 1;
  localparam logic [31:0] SCM_PATTERN    = 32'h5555_5555;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_M0    = 4'd1,
    ST_M1_RD = 4'd2,
    ST_M1_WR = 4'd3,
    ST_M2_RD = 4'd4,
    ST_M2_WR = 4'd5,
    ST_M3    = 4'd6,
    ST_DRAIN = 4'd7,
    ST_DONE  = 4'd8
  } march_state_e;

  typedef enum logic [1:0] {
    EL_M0 = 2'd0,
    EL_M1 = 2'd1,
    EL_M2 = 2'd2,
    EL_M3 = 2'd3
  } march_elem_e;

  function automatic march_elem_e state_elem(input march_state_e st);
    case (st)
      ST_M1_RD, ST_M1_WR: return EL_M1;
      ST_M2_RD, ST_M2_WR: return EL_M2;
      ST_M3:              return EL_M3;
      default:            return EL_M0;
    endcase
  endfunction

  function automatic logic state_is_rd(input march_state_e st);
    return (st == ST_M1_RD) || (st == ST_M2_RD) || (st == ST_M3);
  endfunction

  function automatic logic state_is_wr(input march_state_e st);
    return (st == ST_M0) || (st == ST_M1_WR) || (st == ST_M2_WR);
  endfunction

  // M2 reads the inverse background; M1 writes it.
  function automatic logic elem_rd_inv(input march_elem_e el);
    return (el == EL_M2);
  endfunction

  function automatic logic elem_wr_inv(input march_elem_e el);
    return (el == EL_M1);
  endfunction

endpackage

// File: rtl/scm_bist_cmp.sv
// Read-compare pipeline for the March BIST: tracks each issued read for RD_LAT
// cycles, compares it against mem_dout and accumulates pass/fail_addr/fail_count.
module scm_bist_cmp
  import scm_pkg::*;
#(
  parameter int ADDR_WIDTH = SCM_ADDR_WIDTH,
  parameter int DATA_WIDTH = SCM_DATA_WIDTH,
  parameter int RD_LAT     = SCM_RD_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  rd_valid,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_exp,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [7:0]            fail_count
);

  logic [RD_LAT-1:0]     vld_r;
  logic [DATA_WIDTH-1:0] exp_r [RD_LAT];
  logic [ADDR_WIDTH-1:0] adr_r [RD_LAT];
  logic                  mismatch_s;

  // Delay line aligning each issued read with its mem_dout
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_r <= {RD_LAT{1'b0}};
      for (int i = 0; i < RD_LAT; i++) begin
        exp_r[i] <= {DATA_WIDTH{1'b0}};
        adr_r[i] <= {ADDR_WIDTH{1'b0}};
      end
    end else begin
      vld_r[0] <= rd_valid;
      exp_r[0] <= rd_exp;
      adr_r[0] <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_r[i] <= vld_r[i-1];
        exp_r[i] <= exp_r[i-1];
        adr_r[i] <= adr_r[i-1];
      end
    end
  end

  // Full-width compare at pipeline exit
  always_comb begin
    mismatch_s = 1'b0;
    if (vld_r[RD_LAT-1]) begin
      mismatch_s = (mem_dout != exp_r[RD_LAT-1]);
    end else begin
      mismatch_s = 1'b0;
    end
  end

  // Result registers: cleared by an accepted start, first failing address kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass       <= 1'b0;
      fail_addr  <= {ADDR_WIDTH{1'b0}};
      fail_count <= 8'd0;
    end else if (clr) begin
      pass       <= 1'b1;
      fail_addr  <= {ADDR_WIDTH{1'b0}};
      fail_count <= 8'd0;
    end else if (mismatch_s) begin
      pass <= 1'b0;
      if (fail_count == 8'd0) begin
        fail_addr <= adr_r[RD_LAT-1];
      end
      if (fail_count != 8'hFF) begin
        fail_count <= fail_count + 8'd1;
      end
    end
  end

endmodule

// File: rtl/scm_march_bist.sv
// March BIST initiator for one scm65 instance: sequences M0..M3 over the whole
// array with registered memory-side outputs and reports through scm_bist_cmp.
module scm_march_bist
  import scm_pkg::*;
#(
  parameter int          ADDR_WIDTH = SCM_ADDR_WIDTH,
  parameter int          DATA_WIDTH = SCM_DATA_WIDTH,
  parameter int          RD_LAT     = SCM_RD_LAT,
  parameter logic [31:0] PATTERN    = SCM_PATTERN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [7:0]            fail_count,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_waddr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_re,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_dout
);

  localparam logic [DATA_WIDTH-1:0] PAT        = DATA_WIDTH'(PATTERN);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX   = {ADDR_WIDTH{1'b1}};
  localparam logic [7:0]            DRAIN_LAST = 8'(RD_LAT - 1);

  march_state_e          state_r, state_s;
  march_elem_e           elem_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [7:0]            drain_r, drain_s;
  logic [DATA_WIDTH-1:0] exp_r, exp_s;
  logic                  we_s, re_s, busy_s, done_s, clr_s;
  logic [ADDR_WIDTH-1:0] waddr_s, raddr_s;
  logic [DATA_WIDTH-1:0] din_s;

  // Next state and address counter; wrap happens only at element changes
  always_comb begin
    state_s = state_r;
    addr_s  = addr_r;
    drain_s = drain_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_s = ST_M0;
          addr_s  = ADDR_ZERO;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_M0: begin
        if (addr_r == ADDR_MAX) begin
          state_s = ST_M1_RD;
          addr_s  = ADDR_ZERO;
        end else begin
          addr_s = addr_r + ADDR_ONE;
        end
      end
      ST_M1_RD: state_s = ST_M1_WR;
      ST_M1_WR: begin
        if (addr_r == ADDR_MAX) begin
          state_s = ST_M2_RD;
          addr_s  = ADDR_MAX;
        end else begin
          state_s = ST_M1_RD;
          addr_s  = addr_r + ADDR_ONE;
        end
      end
      ST_M2_RD: state_s = ST_M2_WR;
      ST_M2_WR: begin
        if (addr_r == ADDR_ZERO) begin
          state_s = ST_M3;
          addr_s  = ADDR_MAX;
        end else begin
          state_s = ST_M2_RD;
          addr_s  = addr_r - ADDR_ONE;
        end
      end
      ST_M3: begin
        if (addr_r == ADDR_ZERO) begin
          state_s = ST_DRAIN;
          drain_s = 8'd0;
        end else begin
          addr_s = addr_r - ADDR_ONE;
        end
      end
      ST_DRAIN: begin
        if (drain_r == DRAIN_LAST) begin
          state_s = ST_DONE;
        end else begin
          drain_s = drain_r + 8'd1;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Memory-side values for the state being entered, so they register with it
  always_comb begin
    elem_s  = state_elem(state_s);
    we_s    = state_is_wr(state_s);
    re_s    = state_is_rd(state_s);
    busy_s  = (state_s != ST_IDLE) && (state_s != ST_DONE);
    done_s  = (state_s == ST_DONE);
    clr_s   = (state_r == ST_IDLE) && start;
    waddr_s = mem_waddr;
    din_s   = mem_din;
    raddr_s = mem_raddr;
    exp_s   = exp_r;
    if (we_s) begin
      waddr_s = addr_s;
      din_s   = elem_wr_inv(elem_s) ? ~PAT : PAT;
    end else begin
      waddr_s = mem_waddr;
    end
    if (re_s) begin
      raddr_s = addr_s;
      exp_s   = elem_rd_inv(elem_s) ? ~PAT : PAT;
    end else begin
      raddr_s = mem_raddr;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      addr_r    <= ADDR_ZERO;
      drain_r   <= 8'd0;
      exp_r     <= {DATA_WIDTH{1'b0}};
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_we    <= 1'b0;
      mem_waddr <= ADDR_ZERO;
      mem_din   <= {DATA_WIDTH{1'b0}};
      mem_re    <= 1'b0;
      mem_raddr <= ADDR_ZERO;
    end else begin
      state_r   <= state_s;
      addr_r    <= addr_s;
      drain_r   <= drain_s;
      exp_r     <= exp_s;
      busy      <= busy_s;
      done      <= done_s;
      mem_we    <= we_s;
      mem_waddr <= waddr_s;
      mem_din   <= din_s;
      mem_re    <= re_s;
      mem_raddr <= raddr_s;
    end
  end

  scm_bist_cmp #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .RD_LAT    (RD_LAT)
  ) u_cmp (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_s),
    .rd_valid  (mem_re),
    .rd_addr   (mem_raddr),
    .rd_exp    (exp_r),
    .mem_dout  (mem_dout),
    .pass      (pass),
    .fail_addr (fail_addr),
    .fail_count(fail_count)
  );

endmodule

// File: tb/tb_scm_march_bist.sv
// Bench for scm_march_bist: behavioural scm65 models (RD_LAT 1 and 2) with
// stuck-at-0 faults on bit 0, a table of March runs and hand-written corner cases.
module tb_scm_march_bist;

  localparam int          TMO   = 420;
  localparam logic [31:0] P     = 32'h5555_5555;
  localparam logic [31:0] NP    = 32'hAAAA_AAAA;
  localparam int          LAT1  = 386;   // 1 + 6*64 + RD_LAT(1)
  localparam int          LAT2  = 387;   // 1 + 6*64 + RD_LAT(2)

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0, start2 = 1'b0;
  int   cyc = 0;
  int   checks = 0, errors = 0;
  int   fa1 = -1;

  logic        busy1, done1, pass1, mem_we1, mem_re1;
  logic [5:0]  fail_addr1, mem_waddr1, mem_raddr1;
  logic [7:0]  fail_count1;
  logic [31:0] mem_din1, dout1;
  logic        busy2, done2, pass2, mem_we2, mem_re2;
  logic [5:0]  fail_addr2, mem_waddr2, mem_raddr2;
  logic [7:0]  fail_count2;
  logic [31:0] mem_din2, dout2, d2a;
  logic [31:0] mem1 [64];
  logic [31:0] mem2 [64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  scm_march_bist u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
    .fail_addr(fail_addr1), .fail_count(fail_count1), .mem_we(mem_we1), .mem_waddr(mem_waddr1),
    .mem_din(mem_din1), .mem_re(mem_re1), .mem_raddr(mem_raddr1), .mem_dout(dout1)
  );

  scm_march_bist #(.RD_LAT(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2), .pass(pass2),
    .fail_addr(fail_addr2), .fail_count(fail_count2), .mem_we(mem_we2), .mem_waddr(mem_waddr2),
    .mem_din(mem_din2), .mem_re(mem_re2), .mem_raddr(mem_raddr2), .mem_dout(dout2)
  );

  // scm65 models, read-before-write on the same edge, stuck-at-0 on bit 0
  always @(posedge clk) begin
    if (mem_we1) mem1[mem_waddr1] <= (int'(mem_waddr1) == fa1) ? (mem_din1 & 32'hFFFF_FFFE) : mem_din1;
    if (mem_re1) dout1 <= mem1[mem_raddr1];
  end

  always @(posedge clk) begin
    if (mem_we2) mem2[mem_waddr2] <= (mem_waddr2 == 6'd0 || mem_waddr2 == 6'd63) ? (mem_din2 & 32'hFFFF_FFFE) : mem_din2;
    if (mem_re2) d2a <= mem2[mem_raddr2];
    dout2 <= d2a;
  end

  function automatic int exp_raddr(input int i);
    if (i < 64) return i;
    else if (i < 128) return 127 - i;
    else return 191 - i;
  endfunction

  function automatic int exp_waddr(input int i);
    if (i < 64) return i;
    else if (i < 128) return i - 64;
    else return 191 - i;
  endfunction

  function automatic logic [31:0] exp_wdata(input int i);
    return (i >= 64 && i < 128) ? NP : P;
  endfunction

  // Independent access-sequence monitor for dut1 plus WE/RE exclusivity on both
  int mon_err = 0, rd_n = 0, wr_n = 0, last_rd_n = 0, last_wr_n = 0;
  int m2_first_raddr = -1, m2_last_waddr = -1, m3_last_raddr = -1;
  always @(negedge clk) begin
    if (rst) begin
      rd_n = 0;
      wr_n = 0;
    end else begin
      if (mem_we1 && mem_re1) mon_err++;
      if (mem_we2 && mem_re2) mon_err++;
      if (mem_re1) begin
        if (int'(mem_raddr1) != exp_raddr(rd_n)) mon_err++;
        if (rd_n == 64) m2_first_raddr = int'(mem_raddr1);
        if (rd_n == 191) m3_last_raddr = int'(mem_raddr1);
        rd_n++;
      end
      if (mem_we1) begin
        if (int'(mem_waddr1) != exp_waddr(wr_n) || mem_din1 != exp_wdata(wr_n)) mon_err++;
        if (wr_n == 191) m2_last_waddr = int'(mem_waddr1);
        wr_n++;
      end
      if (done1) begin
        last_rd_n = rd_n;
        last_wr_n = wr_n;
        rd_n = 0;
        wr_n = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int fault;   // stuck-at-0 bit0 address in mem1, -1 = none
    int rp1;     // extra start pulse, cycles after start (0 = none)
    int rp2;
    bit pd;      // pulse start while done is high
    bit pass;
    int fa;
    int fc;
  } vec_t;

  vec_t vecs [6];

  task automatic run1(input vec_t v);
    int c, done_n, done_at, err0;
    logic p_d;
    logic [5:0] fa_d;
    logic [7:0] fc_d;
    fa1 = v.fault;
    err0 = mon_err;
    done_n = 0;
    done_at = -1;
    p_d = 1'b0;
    fa_d = 6'd0;
    fc_d = 8'd0;
    @(negedge clk);
    c = cyc;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    chk("busy_on", 64'(busy1), 64'd1);
    chk("first_wr", 64'({mem_we1, mem_re1, mem_waddr1, mem_din1}), 64'({1'b1, 1'b0, 6'd0, P}));
    for (int i = 2; i <= TMO; i++) begin
      @(negedge clk);
      if (done1) begin
        done_n++;
        if (done_n == 1) begin
          done_at = cyc;
          p_d = pass1;
          fa_d = fail_addr1;
          fc_d = fail_count1;
        end
      end
      start1 = ((i == v.rp1) || (i == v.rp2) || (v.pd && done1)) ? 1'b1 : 1'b0;
    end
    start1 = 1'b0;
    chk("done_count", 64'(done_n), 64'd1);
    chk("done_cycle", 64'(done_at - c), 64'(LAT1));
    chk("pass", 64'(p_d), 64'(v.pass));
    chk("fail_addr", 64'(fa_d), 64'(v.fa));
    chk("fail_count", 64'(fc_d), 64'(v.fc));
    chk("seq_errors", 64'(mon_err - err0), 64'd0);
    chk("n_reads_writes", 64'({last_rd_n[15:0], last_wr_n[15:0]}), 64'({16'd192, 16'd192}));
    chk("idle_after", 64'({busy1, pass1, fail_count1}), 64'({1'b0, v.pass, 8'(v.fc)}));
  endtask

  initial begin
    int c, done_n, done_at, err0;
    vecs[0] = '{fault: -1, rp1: 0,  rp2: 0,   pd: 1'b0, pass: 1'b1, fa: 0,  fc: 0};
    vecs[1] = '{fault: 5,  rp1: 0,  rp2: 0,   pd: 1'b0, pass: 1'b0, fa: 5,  fc: 2};
    vecs[2] = '{fault: -1, rp1: 40, rp2: 190, pd: 1'b1, pass: 1'b1, fa: 0,  fc: 0};
    vecs[3] = '{fault: 0,  rp1: 0,  rp2: 0,   pd: 1'b0, pass: 1'b0, fa: 0,  fc: 2};
    vecs[4] = '{fault: 63, rp1: 0,  rp2: 0,   pd: 1'b0, pass: 1'b0, fa: 63, fc: 2};
    vecs[5] = '{fault: -1, rp1: 0,  rp2: 0,   pd: 1'b0, pass: 1'b1, fa: 0,  fc: 0};

    #1;
    chk("reset_ctl", 64'({busy1, done1, pass1, fail_addr1, fail_count1, mem_we1, mem_re1}), 64'd0);
    chk("reset_mem", 64'({mem_waddr1, mem_raddr1, mem_din1}), 64'd0);
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) run1(vecs[i]);

    chk("m2_first_raddr", 64'(m2_first_raddr), 64'd63);
    chk("m2_last_waddr", 64'(m2_last_waddr), 64'd0);
    chk("m3_last_raddr", 64'(m3_last_raddr), 64'd0);

    // Asynchronous reset in the middle of M1, then a clean rerun
    fa1 = -1;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    repeat (108) @(negedge clk);
    chk("pre_rst_active", 64'(mem_we1 | mem_re1), 64'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_async", 64'({mem_we1, mem_re1, busy1, pass1, fail_count1}), 64'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    run1(vecs[0]);

    // RD_LAT=2 instance, faults at both ends of the array
    err0 = mon_err;
    done_n = 0;
    done_at = -1;
    @(negedge clk);
    c = cyc;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    chk("lat2_busy_on", 64'(busy2), 64'd1);
    for (int i = 2; i <= TMO; i++) begin
      @(negedge clk);
      if (done2) begin
        done_n++;
        if (done_n == 1) done_at = cyc;
      end
    end
    chk("lat2_done_count", 64'(done_n), 64'd1);
    chk("lat2_done_cycle", 64'(done_at - c), 64'(LAT2));
    chk("lat2_result", 64'({pass2, fail_addr2, fail_count2}), 64'({1'b0, 6'd0, 8'd4}));
    chk("lat2_we_re_excl", 64'(mon_err - err0), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
